// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for the MIPS core.
// Write-back source codes, load type codes and register constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10
    } wbsel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } ldtype_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_ext.sv
// Load formatter: picks the addressed big-endian byte/half and extends it.
// Ports: ldtype, addr_lo, mem in; data, misalign, illegal out (combinational).
module load_ext
    import pipe_pkg::*;
(
    input  logic [2:0]  ldtype,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem,
    output logic [31:0] data,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        byte_sel = mem[31:24];
        case (addr_lo)
            2'd0:    byte_sel = mem[31:24];
            2'd1:    byte_sel = mem[23:16];
            2'd2:    byte_sel = mem[15:8];
            default: byte_sel = mem[7:0];
        endcase
    end

    assign half_sel = addr_lo[1] ? mem[15:0] : mem[31:16];

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (ldtype)
            LD_W: begin
                data     = mem;
                misalign = (addr_lo != 2'd0);
            end
            LD_B:  data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU: data = {24'd0, byte_sel};
            LD_H: begin
                data     = {{16{half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            LD_HU: begin
                data     = {16'd0, half_sel};
                misalign = addr_lo[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back formatter.
// Ports: clk, rst, stall, flush, in_* from MEM; we/wr/wd to regfile,
// valid_o, sticky err, retired counter. All outputs are flops.
module wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_regwrite,
    input  logic [4:0]      in_wr,
    input  logic [1:0]      in_wbsel,
    input  logic [2:0]      in_ldtype,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_mem,
    input  logic [XLEN-1:0] in_pc8,
    output logic            we,
    output logic [4:0]      wr,
    output logic [XLEN-1:0] wd,
    output logic            valid_o,
    output logic            err,
    output logic [31:0]     retired
);

    logic [31:0]     ld_data;
    logic            ld_misalign;
    logic            ld_illegal;
    logic [XLEN-1:0] wd_sel;
    logic            bad;
    logic            chk;
    logic            error;
    logic            we_next;
    logic [XLEN-1:0] wd_next;

    load_ext u_load_ext (
        .ldtype   (in_ldtype),
        .addr_lo  (in_addr_lo),
        .mem      (in_mem),
        .data     (ld_data),
        .misalign (ld_misalign),
        .illegal  (ld_illegal)
    );

    always_comb begin
        wd_sel = '0;
        bad    = 1'b0;
        case (in_wbsel)
            WB_ALU:  wd_sel = in_alu;
            WB_LOAD: begin
                wd_sel = ld_data;
                bad    = ld_misalign | ld_illegal;
            end
            WB_LINK: wd_sel = in_pc8;
            default: bad = 1'b1;
        endcase
    end

    // Errors only matter for instructions that would really write.
    assign chk     = in_valid & in_regwrite;
    assign error   = chk & bad;
    assign we_next = chk & (in_wr != REG_ZERO) & ~bad;
    assign wd_next = error ? '0 : wd_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we      <= 1'b0;
            wr      <= '0;
            wd      <= '0;
            valid_o <= 1'b0;
            err     <= 1'b0;
            retired <= '0;
        end else if (flush) begin
            we      <= 1'b0;
            wr      <= '0;
            wd      <= '0;
            valid_o <= 1'b0;
        end else if (!stall) begin
            we      <= we_next;
            wr      <= in_wr;
            wd      <= wd_next;
            valid_o <= in_valid;
            err     <= err | error;
            if (in_valid)
                retired <= retired + 32'd1;
        end
    end

endmodule
